bexkat2_ifetch: RTL and testbench

BEXKAT2_IFETCH -- requirements
Module: bexkat2_ifetch

---
 rtl/bexkat2_ifetch_if.sv | 20 ++
 rtl/bexkat2_ifetch.sv | 140 ++++++++++++++
 tb/tb_bexkat2_ifetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bexkat2_ifetch_if.sv
// Bexkat2 instruction bus bundle.
// Fetch unit is the master; memory/arbiter side is the slave.
interface bexkat2_ifetch_if;
  logic        ins_cyc_o;
  logic        ins_stb_o;
  logic [29:0] ins_adr_o;
  logic [31:0] ins_dat_i;
  logic        ins_ack_i;
  logic        ins_err_i;

  modport master (
    output ins_cyc_o, ins_stb_o, ins_adr_o,
    input  ins_dat_i, ins_ack_i, ins_err_i
  );

  modport slave (
    input  ins_cyc_o, ins_stb_o, ins_adr_o,
    output ins_dat_i, ins_ack_i, ins_err_i
  );
endinterface

// File: rtl/bexkat2_ifetch.sv
// Bexkat2 instruction fetch: single-outstanding bus master feeding
// a DEPTH-entry prefetch queue of {word, pc, fault}.
module bexkat2_ifetch #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  bexkat2_ifetch_if.master bus,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             halt_i,
  output logic             ir_valid_o,
  output logic [31:0]      ir_o,
  output logic [31:0]      ir_pc_o,
  output logic             ir_fault_o,
  input  logic             ir_pop_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DRAIN
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic [29:0]   adr, adr_nx;
  logic          lock, lock_nx;
  logic [CW-1:0] count, count_nx;
  logic [AW-1:0] rd_ptr, wr_ptr;

  logic [31:0]      q_word [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [DEPTH-1:0] q_fault;

  logic        push, pop, can_issue, resp;
  logic [31:0] push_word;
  logic        push_fault;

  assign resp = bus.ins_ack_i || bus.ins_err_i;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    adr_nx      = adr;
    lock_nx     = lock;
    push        = 1'b0;
    push_word   = 32'h0;
    push_fault  = 1'b0;
    pop = ir_pop_i && ir_valid_o && !redirect_i;

    unique case (state)
      F_REQ: begin
        if (resp) begin
          state_nx = F_IDLE;
          // A redirect in the response cycle drops the word.
          if (!redirect_i) begin
            push = 1'b1;
            if (bus.ins_err_i) begin
              push_fault = 1'b1;
              lock_nx    = 1'b1;
            end else begin
              push_word   = bus.ins_dat_i;
              fetch_pc_nx = fetch_pc + 32'd4;
            end
          end
        end else if (redirect_i) begin
          state_nx = F_DRAIN;
        end
      end
      F_DRAIN: begin
        if (resp) state_nx = F_IDLE;
      end
      default: ;
    endcase

    if (redirect_i) begin
      count_nx    = '0;
      fetch_pc_nx = redirect_pc_i & ~32'h3;
      lock_nx     = 1'b0;
    end else begin
      count_nx = count + CW'(push) - CW'(pop);
    end

    // Credit check uses post-pop occupancy so a popping consumer
    // sees one word per cycle.
    can_issue = !redirect_i && !halt_i && !lock_nx &&
                (count_nx < CW'(DEPTH)) &&
                (state_nx == F_IDLE) && (state != F_DRAIN);
    if (can_issue) begin
      state_nx = F_REQ;
      adr_nx   = fetch_pc_nx[31:2];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= F_IDLE;
      fetch_pc <= RESET_VEC;
      adr      <= '0;
      lock     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      adr      <= adr_nx;
      lock     <= lock_nx;
      count    <= count_nx;
      if (redirect_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_word[wr_ptr]  <= push_word;
      q_pc[wr_ptr]    <= fetch_pc;
      q_fault[wr_ptr] <= push_fault;
    end
  end

  assign bus.ins_cyc_o = (state != F_IDLE);
  assign bus.ins_stb_o = (state != F_IDLE);
  assign bus.ins_adr_o = adr;

  assign ir_valid_o = (count != '0);
  assign ir_o       = ir_valid_o ? q_word[rd_ptr] : 32'h0;
  assign ir_pc_o    = ir_valid_o ? q_pc[rd_ptr] : 32'h0;
  assign ir_fault_o = ir_valid_o && q_fault[rd_ptr];
endmodule

// File: tb/tb_bexkat2_ifetch.sv
// Directed bench for bexkat2_ifetch with a zero-wait slave
// whose ack/err are gated by bench controls.
module tb_bexkat2_ifetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        pop = 1'b0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_fault;

  logic        ack_en = 1'b0;
  logic        err_en = 1'b0;
  logic [29:0] err_adr = 30'h0;

  int nvec = 0;
  int nerr = 0;

  bexkat2_ifetch_if bus ();

  bexkat2_ifetch #(.DEPTH(4), .RESET_VEC(32'h0)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .halt_i(halt),
    .ir_valid_o(ir_valid),
    .ir_o(ir),
    .ir_pc_o(ir_pc),
    .ir_fault_o(ir_fault),
    .ir_pop_i(pop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0F0F;
  endfunction

  always_comb begin
    bus.ins_err_i = err_en && bus.ins_cyc_o &&
                    (bus.ins_adr_o == err_adr);
    bus.ins_ack_i = ack_en && bus.ins_cyc_o && !bus.ins_err_i;
    bus.ins_dat_i = word_of({bus.ins_adr_o, 2'b00});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs,
                      input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [29:0] obs,
                      input logic [29:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chkb({tag, "_valid"}, ir_valid, 1'b1);
    chk({tag, "_pc"}, ir_pc, pc);
    chk({tag, "_word"}, ir, word_of(pc));
    chkb({tag, "_fault"}, ir_fault, 1'b0);
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chkb("rst_cyc", bus.ins_cyc_o, 1'b0);
    chkb("rst_stb", bus.ins_stb_o, 1'b0);
    chka("rst_adr", bus.ins_adr_o, 30'h0);
    chkb("rst_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_pc", ir_pc, 32'h0);
    chkb("rst_fault", ir_fault, 1'b0);

    // fill with ack every cycle, no pops
    ack_en = 1'b1;
    rst = 1'b0;
    tick();
    chkb("first_cyc", bus.ins_cyc_o, 1'b1);
    chka("first_adr", bus.ins_adr_o, 30'h0);
    chkb("first_valid", ir_valid, 1'b0);
    tick();
    chka("fill_adr1", bus.ins_adr_o, 30'h1);
    chk_head("fill_head", 32'h0);
    tick();
    chka("fill_adr2", bus.ins_adr_o, 30'h2);
    tick();
    chka("fill_adr3", bus.ins_adr_o, 30'h3);
    tick();
    chkb("full_cyc", bus.ins_cyc_o, 1'b0);
    chk_head("full_head", 32'h0);

    // drain under halt
    pop = 1'b1;
    halt = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk_head("drain", 32'(4 * i));
      chkb("drain_cyc", bus.ins_cyc_o, 1'b0);
    end
    tick();
    chkb("empty_valid", ir_valid, 1'b0);
    tick();
    chkb("underflow_valid", ir_valid, 1'b0);

    // streaming with pop every cycle
    halt = 1'b0;
    tick();
    chkb("stream_cyc", bus.ins_cyc_o, 1'b1);
    chka("stream_adr", bus.ins_adr_o, 30'h4);
    tick();
    chk_head("stream0", 32'h10);
    for (int i = 1; i < 6; i++) begin
      tick();
      chk_head("stream", 32'h10 + 32'(4 * i));
      chkb("stream_cyc", bus.ins_cyc_o, 1'b1);
    end

    // redirect while request outstanding, late ack
    ack_en = 1'b0;
    pop = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    redirect = 1'b0;
    chkb("drain_hold_cyc", bus.ins_cyc_o, 1'b1);
    chka("drain_hold_adr", bus.ins_adr_o, 30'hA);
    chkb("redir_flush", ir_valid, 1'b0);
    tick();
    tick();
    chkb("drain_wait_cyc", bus.ins_cyc_o, 1'b1);
    ack_en = 1'b1;
    tick();
    chkb("drain_done_cyc", bus.ins_cyc_o, 1'b0);
    chkb("drain_dropped", ir_valid, 1'b0);
    tick();
    chkb("redir_cyc", bus.ins_cyc_o, 1'b1);
    chka("redir_adr", bus.ins_adr_o, 30'h400);
    tick();
    chk_head("redir_head", 32'h1000);

    // redirect coincident with ack, then bus error at 0x8
    redirect = 1'b1;
    redirect_pc = 32'h0;
    err_en = 1'b1;
    err_adr = 30'h2;
    tick();
    redirect = 1'b0;
    chkb("redir_ack_drop", ir_valid, 1'b0);
    chkb("redir_ack_cyc", bus.ins_cyc_o, 1'b0);
    tick();
    chka("err_adr0", bus.ins_adr_o, 30'h0);
    tick();
    tick();
    chka("err_adr2", bus.ins_adr_o, 30'h2);
    tick();
    chkb("err_cyc", bus.ins_cyc_o, 1'b0);
    chk_head("err_head", 32'h0);
    tick();
    tick();
    chkb("err_lock_cyc", bus.ins_cyc_o, 1'b0);
    pop = 1'b1;
    tick();
    chk_head("err_pop", 32'h4);
    tick();
    pop = 1'b0;
    chkb("err_valid", ir_valid, 1'b1);
    chk("err_pc", ir_pc, 32'h8);
    chk("err_word", ir, 32'h0);
    chkb("err_fault", ir_fault, 1'b1);
    chkb("err_still_locked", bus.ins_cyc_o, 1'b0);
    err_en = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chkb("unlock_flush", ir_valid, 1'b0);
    tick();
    chkb("unlock_cyc", bus.ins_cyc_o, 1'b1);
    chka("unlock_adr", bus.ins_adr_o, 30'h40);

    // address wrap, then halt
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    chkb("wrap_flush", ir_valid, 1'b0);
    tick();
    chka("wrap_adr_a", bus.ins_adr_o, 30'h3FFF_FFFE);
    tick();
    chka("wrap_adr_b", bus.ins_adr_o, 30'h3FFF_FFFF);
    tick();
    chkb("wrap_cyc", bus.ins_cyc_o, 1'b1);
    chka("wrap_adr_0", bus.ins_adr_o, 30'h0);
    halt = 1'b1;
    tick();
    chkb("halt_cyc", bus.ins_cyc_o, 1'b0);
    chk_head("halt_head", 32'hFFFF_FFF8);
    pop = 1'b1;
    tick();
    chk_head("halt_pop1", 32'hFFFF_FFFC);
    tick();
    chk_head("halt_pop2", 32'h0);
    tick();
    pop = 1'b0;
    chkb("halt_empty", ir_valid, 1'b0);
    chkb("halt_idle", bus.ins_cyc_o, 1'b0);

    // asynchronous reset with a cycle outstanding and 3 entries
    halt = 1'b0;
    tick();
    chka("pre_rst_adr1", bus.ins_adr_o, 30'h1);
    tick();
    tick();
    tick();
    chkb("pre_rst_cyc", bus.ins_cyc_o, 1'b1);
    chka("pre_rst_adr4", bus.ins_adr_o, 30'h4);
    chk_head("pre_rst_head", 32'h4);
    ack_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chkb("arst_cyc", bus.ins_cyc_o, 1'b0);
    chkb("arst_stb", bus.ins_stb_o, 1'b0);
    chkb("arst_valid", ir_valid, 1'b0);
    chka("arst_adr", bus.ins_adr_o, 30'h0);
    tick();
    rst = 1'b0;
    ack_en = 1'b1;
    tick();
    chkb("refetch_cyc", bus.ins_cyc_o, 1'b1);
    chka("refetch_adr", bus.ins_adr_o, 30'h0);
    tick();
    chk_head("refetch_head", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
